// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and types.
// Holds the 640x480 @ 60 Hz default timing, derived line/frame totals,
// sync polarity constants and the per-axis timing bundle typedef.
package vga_timing_pkg;

    localparam int unsigned COUNT_W = 32;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // One axis of raster timing, in clocks (horizontal) or lines (vertical).
    typedef struct packed {
        logic [31:0] visible;
        logic [31:0] front;
        logic [31:0] sync;
        logic [31:0] back;
    } axis_timing_t;

    localparam axis_timing_t DEF_H_TIMING = '{
        visible: 32'(DEF_H_VISIBLE), front: 32'(DEF_H_FRONT),
        sync:    32'(DEF_H_SYNC),    back:  32'(DEF_H_BACK)
    };

    function automatic int unsigned axis_total(axis_timing_t t);
        return int'(t.visible + t.front + t.sync + t.back);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrap counter for one raster axis.
// Ports: clk, reset (sync, active-high), enable (advance this cycle),
//        count (registered position), wrap_c (enabled and at terminal count),
//        sync_c / visible_c (window decodes of the NEXT count, so the parent
//        can register them and stay aligned with count).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter axis_timing_t CFG      = DEF_H_TIMING,
    parameter bit           SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic [COUNT_W-1:0] count,
    output logic               wrap_c,
    output logic               sync_c,
    output logic               visible_c
);

    localparam int unsigned TOTAL      = axis_total(CFG);
    localparam int unsigned SYNC_FIRST = int'(CFG.visible + CFG.front);
    localparam int unsigned SYNC_END   = SYNC_FIRST + int'(CFG.sync);

    logic [COUNT_W-1:0] count_next;

    // Next count and its window decodes.
    always_comb begin
        count_next = count;
        wrap_c     = enable && (count == COUNT_W'(TOTAL - 1));
        if (enable) begin
            count_next = wrap_c ? '0 : count + COUNT_W'(1);
        end
        visible_c = (count_next < CFG.visible);
        sync_c    = ((count_next >= COUNT_W'(SYNC_FIRST)) &&
                     (count_next <  COUNT_W'(SYNC_END))) ? SYNC_POL : !SYNC_POL;
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing generator: cascaded horizontal/vertical counters with
// registered sync, display-enable and line/frame strobes aligned to row/column.
// Ports: vga_clock, reset (sync, active-high), row, column, display_enable,
//        hsync, vsync, line_start, frame_start.
// Option: define VGA_SYNC_ALIGN_EN to delay display_enable/hsync/vsync by one
//         extra register stage (row/column and strobes unchanged).
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT    = DEF_H_FRONT,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BACK     = DEF_H_BACK,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT    = DEF_V_FRONT,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BACK     = DEF_V_BACK,
    parameter bit          H_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter bit          V_SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic               vga_clock,
    input  logic               reset,
    output logic [COUNT_W-1:0] row,
    output logic [COUNT_W-1:0] column,
    output logic               display_enable,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start
);

    localparam axis_timing_t H_CFG = '{
        visible: 32'(H_VISIBLE), front: 32'(H_FRONT),
        sync:    32'(H_SYNC),    back:  32'(H_BACK)
    };
    localparam axis_timing_t V_CFG = '{
        visible: 32'(V_VISIBLE), front: 32'(V_FRONT),
        sync:    32'(V_SYNC),    back:  32'(V_BACK)
    };

    // Low for the first clock after reset so (0,0) is presented once with
    // its decodes before counting starts.
    logic running;
    logic h_wrap_c, h_sync_c, h_visible_c;
    logic v_wrap_c, v_sync_c, v_visible_c;
    logic de_q, hsync_q, vsync_q;

    vga_axis_counter #(
        .CFG      (H_CFG),
        .SYNC_POL (H_SYNC_POL)
    ) u_h_axis (
        .clk       (vga_clock),
        .reset     (reset),
        .enable    (running),
        .count     (column),
        .wrap_c    (h_wrap_c),
        .sync_c    (h_sync_c),
        .visible_c (h_visible_c)
    );

    vga_axis_counter #(
        .CFG      (V_CFG),
        .SYNC_POL (V_SYNC_POL)
    ) u_v_axis (
        .clk       (vga_clock),
        .reset     (reset),
        .enable    (h_wrap_c),
        .count     (row),
        .wrap_c    (v_wrap_c),
        .sync_c    (v_sync_c),
        .visible_c (v_visible_c)
    );

    // Registered decodes of the next position; a wrap means next is column 0
    // (line) or (0,0) (frame).
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            running     <= 1'b0;
            de_q        <= 1'b0;
            hsync_q     <= !H_SYNC_POL;
            vsync_q     <= !V_SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running     <= 1'b1;
            de_q        <= h_visible_c && v_visible_c;
            hsync_q     <= h_sync_c;
            vsync_q     <= v_sync_c;
            line_start  <= !running || h_wrap_c;
            frame_start <= !running || v_wrap_c;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic de_d, hsync_d, vsync_d;

    // Extra stage to match a one-cycle registered colour path.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            de_d    <= 1'b0;
            hsync_d <= !H_SYNC_POL;
            vsync_d <= !V_SYNC_POL;
        end else begin
            de_d    <= de_q;
            hsync_d <= hsync_q;
            vsync_d <= vsync_q;
        end
    end

    assign display_enable = de_d;
    assign hsync          = hsync_d;
    assign vsync          = vsync_d;
`else
    assign display_enable = de_q;
    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: default 640x480 instance plus a tiny-timing instance,
// sharing clock and reset. Expected outputs come from a closed-form model of
// cycles since reset release.
module tb_vga_timing_generator;

    typedef struct {
        int unsigned hv, hf, hs, hb, vv, vf, vs, vb;
    } tim_t;

    typedef struct {
        logic [31:0] row;
        logic [31:0] col;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d_row, d_col, s_row, s_col;
    logic        d_de, d_hs, d_vs, d_ls, d_fs;
    logic        s_de, s_hs, s_vs, s_ls, s_fs;

    always #5 clk = ~clk;

    vga_timing_generator u_dut_def (
        .vga_clock      (clk),
        .reset          (reset),
        .row            (d_row),
        .column         (d_col),
        .display_enable (d_de),
        .hsync          (d_hs),
        .vsync          (d_vs),
        .line_start     (d_ls),
        .frame_start    (d_fs)
    );

    vga_timing_generator #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (1),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
    ) u_dut_sml (
        .vga_clock      (clk),
        .reset          (reset),
        .row            (s_row),
        .column         (s_col),
        .display_enable (s_de),
        .hsync          (s_hs),
        .vsync          (s_vs),
        .line_start     (s_ls),
        .frame_start    (s_fs)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t q_def[$];
    obs_t q_sml[$];
    tim_t t_def, t_sml;
    obs_t prev_def, prev_sml;
    int unsigned k   = 0;
    int          cyc = 0;

    // Period / pulse-width trackers.
    int  d_ls_last, s_fs_last;
    bit  d_ls_valid, s_fs_valid;
    int  d_hs_run, s_hs_run, s_vs_run;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic obs_t reset_obs();
        obs_t o;
        o.row = 0; o.col = 0; o.de = 1'b0;
        o.hs = 1'b1; o.vs = 1'b1; o.ls = 1'b0; o.fs = 1'b0;
        return o;
    endfunction

    function automatic obs_t model_raw(input tim_t t, input int unsigned kk);
        obs_t o;
        int unsigned ht, vt, c, r;
        ht = t.hv + t.hf + t.hs + t.hb;
        vt = t.vv + t.vf + t.vs + t.vb;
        c  = kk % ht;
        r  = (kk / ht) % vt;
        o.col = c;
        o.row = r;
        o.de  = (c < t.hv) && (r < t.vv);
        o.hs  = !((c >= t.hv + t.hf) && (c < t.hv + t.hf + t.hs));
        o.vs  = !((r >= t.vv + t.vf) && (r < t.vv + t.vf + t.vs));
        o.ls  = (c == 0);
        o.fs  = (c == 0) && (r == 0);
        return o;
    endfunction

    task automatic predict(input tim_t t, input logic rst, input int unsigned kk,
                           inout obs_t prev_raw, output obs_t e);
        obs_t raw;
        if (rst) begin
            e        = reset_obs();
            prev_raw = reset_obs();
        end else begin
            raw = model_raw(t, kk);
            e   = raw;
`ifdef VGA_SYNC_ALIGN_EN
            e.de = prev_raw.de;
            e.hs = prev_raw.hs;
            e.vs = prev_raw.vs;
`endif
            prev_raw = raw;
        end
    endtask

    task automatic compare_obs(input string tag, input obs_t g, input obs_t e);
        check_eq({tag, ".row"},         g.row, e.row);
        check_eq({tag, ".column"},      g.col, e.col);
        check_eq({tag, ".de"},          32'(g.de), 32'(e.de));
        check_eq({tag, ".hsync"},       32'(g.hs), 32'(e.hs));
        check_eq({tag, ".vsync"},       32'(g.vs), 32'(e.vs));
        check_eq({tag, ".line_start"},  32'(g.ls), 32'(e.ls));
        check_eq({tag, ".frame_start"}, 32'(g.fs), 32'(e.fs));
    endtask

    // One clock: drive reset, queue the prediction, sample after the edge.
    task automatic step(input logic rst);
        obs_t e, gd, gs;
        reset = rst;
        predict(t_def, rst, k, prev_def, e);
        q_def.push_back(e);
        predict(t_sml, rst, k, prev_sml, e);
        q_sml.push_back(e);
        if (rst) k = 0;
        else     k++;

        @(posedge clk);
        #1;
        cyc++;
        gd.row = d_row; gd.col = d_col; gd.de = d_de; gd.hs = d_hs;
        gd.vs = d_vs; gd.ls = d_ls; gd.fs = d_fs;
        gs.row = s_row; gs.col = s_col; gs.de = s_de; gs.hs = s_hs;
        gs.vs = s_vs; gs.ls = s_ls; gs.fs = s_fs;
        compare_obs("def", gd, q_def.pop_front());
        compare_obs("sml", gs, q_sml.pop_front());

        if (rst) begin
            d_ls_valid = 0; s_fs_valid = 0;
            d_hs_run = 0; s_hs_run = 0; s_vs_run = 0;
        end else begin
            if (gd.ls) begin
                if (d_ls_valid) check_eq("def.line_period", 32'(cyc - d_ls_last), 32'd800);
                d_ls_last = cyc; d_ls_valid = 1;
            end
            if (gs.fs) begin
                if (s_fs_valid) check_eq("sml.frame_period", 32'(cyc - s_fs_last), 32'd98);
                s_fs_last = cyc; s_fs_valid = 1;
            end
            if (!gd.hs) d_hs_run++;
            else if (d_hs_run != 0) begin
                check_eq("def.hsync_width", 32'(d_hs_run), 32'd96);
                d_hs_run = 0;
            end
            if (!gs.hs) s_hs_run++;
            else if (s_hs_run != 0) begin
                check_eq("sml.hsync_width", 32'(s_hs_run), 32'd3);
                s_hs_run = 0;
            end
            if (!gs.vs) s_vs_run++;
            else if (s_vs_run != 0) begin
                check_eq("sml.vsync_width", 32'(s_vs_run), 32'd14);
                s_vs_run = 0;
            end
        end
    endtask

    initial begin
        t_def = '{640, 16, 96, 48, 480, 10, 2, 33};
        t_sml = '{8, 2, 3, 1, 4, 1, 1, 1};
        prev_def = reset_obs();
        prev_sml = reset_obs();
        d_ls_valid = 0; s_fs_valid = 0;
        d_ls_last = 0;  s_fs_last = 0;
        d_hs_run = 0; s_hs_run = 0; s_vs_run = 0;
        reset = 1'b1;

        // Reset held five cycles, then run into the third small frame.
        for (int i = 0; i < 5; i++) step(1'b1);
        for (int i = 0; i < 229; i++) step(1'b0);

        // Single-cycle reset mid-frame (small instance at row 2, column 5).
        step(1'b1);

        // Restart and run past two full default lines.
        for (int i = 0; i < 1700; i++) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
